cf_sync_fifo: RTL and testbench
===============================

Name: cf_sync_fifo

Overview:
- Parametrised synchronous first-word-fall-through (FWFT) FIFO with a valid/ready handshake on both sides.
- Buffers symbol words between the Chien search and Forney evaluator stages of the RS(544,514) decoder.
- Each entry carries LANES parallel GF symbols.
- Adds occupancy, programmable almost-full/almost-empty thresholds, synchronous flush and a high-watermark monitor, replacing the bare addressed RAM used as FIFO storage.

Parameters:
- ADDR_WIDTH, 4: log2 of capacity. DEPTH = 2^ADDR_WIDTH entries, minimum ADDR_WIDTH = 1.
- DATA_WIDTH, 10: bits per symbol.
- LANES, 4: symbols per entry. Entry width W = LANES*DATA_WIDTH.
- AF_LEVEL, DEPTH-2: almost_full_o asserts when count >= AF_LEVEL. Legal range 1..DEPTH.
- AE_LEVEL, 1: almost_empty_o asserts when count <= AE_LEVEL. Legal range 0..DEPTH-1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous clear of FIFO contents.
- wr_valid_i  in  1  write request.
- wr_ready_o  out  1  FIFO can accept an entry.
- wr_data_i  in  W  write entry. Lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- rd_valid_o  out  1  rd_data_o holds the oldest entry.
- rd_ready_i  in  1  consumer accepts rd_data_o.
- rd_data_o  out  W  oldest entry, registered.
- count_o  out  ADDR_WIDTH+1  entries held, including the output register.
- almost_full_o  out  1  count_o >= AF_LEVEL.
- almost_empty_o  out  1  count_o <= AE_LEVEL.
- max_count_o  out  ADDR_WIDTH+1  highest count_o since reset or flush.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - Pointers, count_o, max_count_o = 0.
  - rd_valid_o = 0, rd_data_o = 0, wr_ready_o = 1.
  - almost_empty_o = 1, almost_full_o = 0.
  - Storage array cleared to 0.
  - Reset asserted mid-transfer discards all contents; no partial state survives.
- Push occurs when wr_valid_i && wr_ready_o at the clock edge. Pop occurs when rd_valid_o && rd_ready_i.
- wr_ready_o is a registered function of count only: count_o < DEPTH. There is no combinational path from rd_ready_i to wr_ready_o.
  - When full, a same-cycle pop does not enable a push; the push is accepted the following cycle.
- FWFT latency: a push into an empty FIFO at edge N drives rd_valid_o=1 with rd_data_o = that entry after edge N (visible in cycle N+1).
- rd_data_o changes only on a pop or on a load into an empty output register. It is stable while rd_valid_o && !rd_ready_i.
- Pop with more entries behind: the next entry appears on rd_data_o the cycle after the pop, with no bubble.
- Pop of the last entry with a simultaneous push (count 1): the new entry loads directly into the output register. rd_valid_o stays 1 and count_o stays 1.
- Count update each cycle:
  - push only: count_o += 1
  - pop only: count_o -= 1
  - both: unchanged
- Pointers wrap modulo DEPTH with no special-case logic.
- Flags: almost_full_o, almost_empty_o and wr_ready_o are registered and consistent with count_o in the same cycle.
- max_count_o updates to max(max_count_o, next count) every cycle.
- flush_i (synchronous) has priority over push and pop in the same cycle:
  - Clears pointers, count_o, rd_valid_o and max_count_o.
  - rd_data_o holds its value.
  - Storage array contents are not cleared.
  - A push presented in the flush cycle is dropped, even though wr_ready_o was 1.
- Storage: a single-write, single-read array of DEPTH x W, written only on push.
- Illegal parameter values are caught by an elaboration-time check.

Test Plan:
- Reset/idle (ADDR_WIDTH=2, LANES=2, DATA_WIDTH=10): after reset release → count_o=0, rd_valid_o=0, wr_ready_o=1, almost_empty_o=1, rd_data_o=0.
- Fill, then drain with rd_ready_i=0 during fill:
  - Push 0x001..0x004 in lane 0 on consecutive cycles → count_o=4, wr_ready_o=0, almost_full_o=1 (AF_LEVEL=2 from count 2).
  - A fifth push is not accepted.
  - Drain with rd_ready_i=1 → 0x001, 0x002, 0x003, 0x004 in order on 4 consecutive cycles.
- FWFT latency: push 0x3FF into empty at edge N → rd_valid_o=1, rd_data_o=0x3FF in cycle N+1.
- Simultaneous push/pop:
  - At count 1 → count stays 1, no bubble on rd_valid_o.
  - At count 4 → pop accepted, push refused, wr_ready_o=1 the next cycle.
- Wrap-around: 10 continuous push/pop cycles with alternating stall patterns → output sequence equals input sequence, count_o never exceeds 4, max_count_o matches a reference model.
- Flush and asynchronous reset:
  - flush_i with count 3 plus a same-cycle push → count_o=0, rd_valid_o=0, max_count_o=0, pushed entry lost.
  - rst_ni low for one cycle mid-stream → all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cf_sync_fifo_if.sv
// cf_sync_fifo_if: producer/consumer bundle for cf_sync_fifo.
//
// Both sides use the same valid/ready rule: a transfer happens on a rising
// clock edge where valid and ready are both 1. A source holds valid and its
// data stable until that edge.
//
// Signals:
//   wr_valid  producer has an entry on wr_data
//   wr_ready  FIFO can accept an entry (registered, depends on count only)
//   wr_data   entry to write, W bits
//   rd_valid  rd_data holds the oldest entry
//   rd_ready  consumer accepts rd_data
//   rd_data   oldest entry, W bits, registered
//
// Modports:
//   master  the environment driving the FIFO (producer and consumer)
//   slave   the FIFO itself
interface cf_sync_fifo_if #(
    parameter int W = 40
) ();
    logic         wr_valid;
    logic         wr_ready;
    logic [W-1:0] wr_data;
    logic         rd_valid;
    logic         rd_ready;
    logic [W-1:0] rd_data;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/cf_sync_fifo.sv
// cf_sync_fifo: first-word-fall-through FIFO buffering LANES-wide GF symbol
// entries between the Chien search and Forney evaluator stages.
//
// The head entry lives in a dedicated output register, so rd_data is always
// a flop output. count_o counts every entry held, including that register.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   flush_i         synchronous clear; beats push and pop in the same cycle
//   fifo            cf_sync_fifo_if.slave (write and read handshakes)
//   count_o         entries held, 0..DEPTH
//   almost_full_o   count_o >= AF_LEVEL
//   almost_empty_o  count_o <= AE_LEVEL
//   max_count_o     highest count_o since reset or flush
module cf_sync_fifo #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 10,
    parameter int LANES      = 4,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    cf_sync_fifo_if.slave         fifo,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   max_count_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int W     = LANES * DATA_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]         AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0]         AE_C    = CW'(AE_LEVEL);
    localparam logic [CW-1:0]         ONE_C   = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    if (ADDR_WIDTH < 1 || DATA_WIDTH < 1 || LANES < 1 ||
        AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
        AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_param_check
        $error("cf_sync_fifo: illegal parameter combination");
    end

    logic [W-1:0]          mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_next;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         max_q, max_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [W-1:0]          rd_data_q, rd_data_d;
    logic                  wr_ready_q, af_q, ae_q;
    logic                  push, pop;

    // wr_ready_q depends only on the registered count, so a pop in a full
    // cycle cannot let a push through until the next cycle.
    assign push = fifo.wr_valid & wr_ready_q;
    assign pop  = rd_valid_q & fifo.rd_ready;

    // The memory holds every live entry at rd_ptr..rd_ptr+count-1; the
    // output register mirrors mem[rd_ptr]. After a pop the next head is at
    // rd_ptr+1, which is already written whenever count was at least 2.
    assign rd_ptr_next = rd_ptr_q + PTR_ONE;

    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;

        if (push && !pop) begin
            count_d = count_q + ONE_C;
        end else if (pop && !push) begin
            count_d = count_q - ONE_C;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_next;
        end

        if (pop) begin
            if (count_q > ONE_C) begin
                rd_valid_d = 1'b1;
                rd_data_d  = mem_q[rd_ptr_next];
            end else if (push) begin
                // Last entry leaves while a new one arrives: bypass the
                // memory so rd_valid never drops.
                rd_valid_d = 1'b1;
                rd_data_d  = fifo.wr_data;
            end else begin
                rd_valid_d = 1'b0;
            end
        end else if (!rd_valid_q && push) begin
            rd_valid_d = 1'b1;
            rd_data_d  = fifo.wr_data;
        end

        if (flush_i) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            rd_valid_d = 1'b0;
            rd_data_d  = rd_data_q;
        end

        max_d = (count_d > max_q) ? count_d : max_q;
        if (flush_i) begin
            max_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q    <= '0;
            max_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            wr_ready_q <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
        end else begin
            count_q    <= count_d;
            max_q      <= max_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            // Flags are computed from the next count so they line up with
            // count_o in the same cycle.
            wr_ready_q <= (count_d < DEPTH_C);
            af_q       <= (count_d >= AF_C);
            ae_q       <= (count_d <= AE_C);
        end
    end

    // Flush drops a same-cycle push, so the memory is not written then.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !flush_i) begin
            mem_q[wr_ptr_q] <= fifo.wr_data;
        end
    end

    assign fifo.wr_ready  = wr_ready_q;
    assign fifo.rd_valid  = rd_valid_q;
    assign fifo.rd_data   = rd_data_q;
    assign count_o        = count_q;
    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;
    assign max_count_o    = max_q;

endmodule

// File: tb/tb_cf_sync_fifo.sv
// tb_cf_sync_fifo: self-checking bench for cf_sync_fifo with DEPTH=4,
// two 10-bit lanes, AF_LEVEL=2, AE_LEVEL=1.
// Inputs change on the falling edge; outputs are compared on the falling
// edge after each rising edge. The reference is a plain queue of entries.
module tb_cf_sync_fifo;

    localparam int AW    = 2;
    localparam int DW    = 10;
    localparam int LN    = 2;
    localparam int AF    = 2;
    localparam int AE    = 1;
    localparam int W     = LN * DW;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [AW:0]   count;
    logic [AW:0]   max_count;
    logic          af;
    logic          ae;

    cf_sync_fifo_if #(.W(W)) bus ();

    cf_sync_fifo #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LANES      (LN),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .fifo           (bus),
        .count_o        (count),
        .almost_full_o  (af),
        .almost_empty_o (ae),
        .max_count_o    (max_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / reference ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_data;
    int           m_max;
    int           checks;
    int           errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_data = '0;
        m_max  = 0;
    endtask

    // One clock: apply inputs at the falling edge, advance the reference by
    // the handshake rules, return at the next falling edge.
    task automatic drive_cycle(input logic fl, input logic wv, input logic [W-1:0] wd,
                               input logic rr);
        bit acc_push;
        bit acc_pop;
        flush        = fl;
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        acc_push = wv && (exp_q.size() < DEPTH);
        acc_pop  = rr && (exp_q.size() > 0);
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
            m_max = 0;
        end else begin
            if (acc_pop) void'(exp_q.pop_front());
            if (acc_push) exp_q.push_back(wd);
            if (exp_q.size() > m_max) m_max = exp_q.size();
        end
        if (exp_q.size() > 0) m_data = exp_q[0];
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        int n;
        n = exp_q.size();
        check({tag, ".count"},    32'(count),         32'(n));
        check({tag, ".rd_valid"}, 32'(bus.rd_valid),  32'(n > 0));
        check({tag, ".rd_data"},  32'(bus.rd_data),   32'(m_data));
        check({tag, ".wr_ready"}, 32'(bus.wr_ready),  32'(n < DEPTH));
        check({tag, ".af"},       32'(af),            32'(n >= AF));
        check({tag, ".ae"},       32'(ae),            32'(n <= AE));
        check({tag, ".max"},      32'(max_count),     32'(m_max));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".count"},    32'(count),        32'd0);
        check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'd0);
        check({tag, ".rd_data"},  32'(bus.rd_data),  32'd0);
        check({tag, ".wr_ready"}, 32'(bus.wr_ready), 32'd1);
        check({tag, ".af"},       32'(af),           32'd0);
        check({tag, ".ae"},       32'(ae),           32'd1);
        check({tag, ".max"},      32'(max_count),    32'd0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic         fl;
        logic         wv;
        logic [W-1:0] wd;
        logic         rr;
        int           cnt;
        logic         vld;
        logic [W-1:0] dat;
        logic         wrr;
        logic         exp_af;
        logic         exp_ae;
        int           mx;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs[NVEC];

    initial begin
        checks = 0;
        errors = 0;
        // fl wv  data         rr  cnt vld data         wrr af ae max
        vecs[0]  = '{1'b0, 1'b1, 20'h00001, 1'b0, 1, 1'b1, 20'h00001, 1'b1, 1'b0, 1'b1, 1};
        vecs[1]  = '{1'b0, 1'b1, 20'h00002, 1'b0, 2, 1'b1, 20'h00001, 1'b1, 1'b1, 1'b0, 2};
        vecs[2]  = '{1'b0, 1'b1, 20'h00003, 1'b0, 3, 1'b1, 20'h00001, 1'b1, 1'b1, 1'b0, 3};
        vecs[3]  = '{1'b0, 1'b1, 20'h00004, 1'b0, 4, 1'b1, 20'h00001, 1'b0, 1'b1, 1'b0, 4};
        vecs[4]  = '{1'b0, 1'b1, 20'h00005, 1'b0, 4, 1'b1, 20'h00001, 1'b0, 1'b1, 1'b0, 4};
        vecs[5]  = '{1'b0, 1'b0, 20'h00000, 1'b1, 3, 1'b1, 20'h00002, 1'b1, 1'b1, 1'b0, 4};
        vecs[6]  = '{1'b0, 1'b0, 20'h00000, 1'b1, 2, 1'b1, 20'h00003, 1'b1, 1'b1, 1'b0, 4};
        vecs[7]  = '{1'b0, 1'b0, 20'h00000, 1'b1, 1, 1'b1, 20'h00004, 1'b1, 1'b0, 1'b1, 4};
        vecs[8]  = '{1'b0, 1'b0, 20'h00000, 1'b1, 0, 1'b0, 20'h00004, 1'b1, 1'b0, 1'b1, 4};
        vecs[9]  = '{1'b0, 1'b1, 20'h003FF, 1'b0, 1, 1'b1, 20'h003FF, 1'b1, 1'b0, 1'b1, 4};
        vecs[10] = '{1'b0, 1'b1, 20'h000AA, 1'b1, 1, 1'b1, 20'h000AA, 1'b1, 1'b0, 1'b1, 4};
        vecs[11] = '{1'b0, 1'b1, 20'h000BB, 1'b0, 2, 1'b1, 20'h000AA, 1'b1, 1'b1, 1'b0, 4};
        vecs[12] = '{1'b0, 1'b1, 20'h000CC, 1'b0, 3, 1'b1, 20'h000AA, 1'b1, 1'b1, 1'b0, 4};
        vecs[13] = '{1'b0, 1'b1, 20'h000DD, 1'b0, 4, 1'b1, 20'h000AA, 1'b0, 1'b1, 1'b0, 4};
        vecs[14] = '{1'b0, 1'b1, 20'h000EE, 1'b1, 3, 1'b1, 20'h000BB, 1'b1, 1'b1, 1'b0, 4};
        vecs[15] = '{1'b0, 1'b1, 20'h000EE, 1'b0, 4, 1'b1, 20'h000BB, 1'b0, 1'b1, 1'b0, 4};
        vecs[16] = '{1'b0, 1'b0, 20'h00000, 1'b1, 3, 1'b1, 20'h000CC, 1'b1, 1'b1, 1'b0, 4};
        vecs[17] = '{1'b1, 1'b1, 20'h000FF, 1'b0, 0, 1'b0, 20'h000CC, 1'b1, 1'b0, 1'b1, 0};
        vecs[18] = '{1'b0, 1'b0, 20'h00000, 1'b0, 0, 1'b0, 20'h000CC, 1'b1, 1'b0, 1'b1, 0};
        vecs[19] = '{1'b0, 1'b1, 20'hA9523, 1'b0, 1, 1'b1, 20'hA9523, 1'b1, 1'b0, 1'b1, 1};

        flush        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        rst_n        = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_values("reset");
        @(negedge clk);
        check_reset_values("idle");

        // Directed table: fill/overfill/drain, FWFT, simultaneous push/pop,
        // flush with a dropped push.
        for (int i = 0; i < NVEC; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive_cycle(vecs[i].fl, vecs[i].wv, vecs[i].wd, vecs[i].rr);
            check({tag, ".count"},    32'(count),        32'(vecs[i].cnt));
            check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(vecs[i].vld));
            check({tag, ".rd_data"},  32'(bus.rd_data),  32'(vecs[i].dat));
            check({tag, ".wr_ready"}, 32'(bus.wr_ready), 32'(vecs[i].wrr));
            check({tag, ".af"},       32'(af),           32'(vecs[i].exp_af));
            check({tag, ".ae"},       32'(ae),           32'(vecs[i].exp_ae));
            check({tag, ".max"},      32'(max_count),    32'(vecs[i].mx));
        end

        // Wrap-around: continuous pushes with alternating consumer stalls.
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, 1'b1, W'(32'h100 + i), ((i / 2) % 2) == 1);
            check_model($sformatf("wrap%0d", i));
            check("wrap.bound", 32'(count <= DEPTH), 32'd1);
        end
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, 1'b0, '0, 1'b1);
            check_model($sformatf("drain%0d", i));
        end

        // Randomized traffic in phases of differing producer/consumer pressure.
        for (int i = 0; i < 600; i++) begin
            int phase;
            logic fl, wv, rr;
            phase = (i / 50) % 3;
            fl = ($urandom_range(0, 59) == 0);
            case (phase)
                0:       begin wv = ($urandom_range(0, 3) != 0); rr = ($urandom_range(0, 3) == 0); end
                1:       begin wv = ($urandom_range(0, 3) == 0); rr = ($urandom_range(0, 3) != 0); end
                default: begin wv = $urandom_range(0, 1) == 1;   rr = $urandom_range(0, 1) == 1;   end
            endcase
            drive_cycle(fl, wv, W'($urandom()), rr);
            check_model($sformatf("rand%0d", i));
        end

        // Asynchronous reset in the middle of traffic.
        drive_cycle(1'b0, 1'b1, 20'h11111, 1'b0);
        drive_cycle(1'b0, 1'b1, 20'h22222, 1'b0);
        drive_cycle(1'b0, 1'b1, 20'h33333, 1'b0);
        check("pre_reset.count", 32'(count > 0), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1'b0, 1'b0, '0, 1'b1);
        check_model("post_reset_idle");
        drive_cycle(1'b0, 1'b1, 20'h0ABCD, 1'b0);
        check_model("post_reset_push");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
